// File: rtl/intr_controller_pkg.sv
// Shared definitions for the interrupt controller and the processor vector logic.
//   - FSM state encodings (IDLE / REQ / SERVICE)
//   - default source count, vector width, base vector and vector stride
//   - id_width(): width of a source index for a given source count
package intr_controller_pkg;

    // FSM state encodings, kept as plain 2-bit constants for legacy users
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    // Defaults shared with the processor's vector fetch logic
    localparam int unsigned DEF_NUM_SRC    = 4;
    localparam int unsigned DEF_ADDR_W     = 32;
    localparam logic [31:0] DEF_BASE_VEC   = 32'h0000_0100;
    localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;

    // Source index width; a single source still needs a 1-bit id
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/intr_controller_prio_enc.sv
// Combinational lowest-index-first priority encoder.
// Ports:
//   req     in   NUM_SRC  request vector (bit 0 = highest priority)
//   id_c    out  ID_W     index of the lowest set bit (0 when none set)
//   valid_c out  1        at least one request bit is set
module intr_controller_prio_enc #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [ID_W-1:0]    id_c,
    output logic               valid_c
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        id_c    = '0;
        valid_c = 1'b0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                id_c    = ID_W'(i);
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intr_controller.sv
// Prioritised interrupt controller feeding the processor's single intr pin.
// Latches rising edges of the request lines into a pending register, masks
// them, selects the highest-priority (lowest index) enabled source and runs a
// single-level request / service handshake with the processor.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   irq_in       request lines, rising-edge sensitive
//   gie          global interrupt enable
//   mask_we      mask register write strobe
//   mask_wdata   new mask value (1 = enabled)
//   mask         current mask register
//   irq_req      interrupt request to processor
//   irq_vec      vector address, valid while irq_req=1
//   irq_id       source index, valid while irq_req=1 or in_service=1
//   cpu_ack      processor accepts the request
//   cpu_rti      processor executed return-from-interrupt
//   in_service   an acknowledged interrupt is being serviced
//   pending      pending register
module intr_controller
    import intr_controller_pkg::*;
#(
    parameter int unsigned       NUM_SRC    = DEF_NUM_SRC,
    parameter int unsigned       ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_VEC   = ADDR_W'(DEF_BASE_VEC),
    parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(DEF_VEC_STRIDE),
    localparam int unsigned      ID_W       = id_width(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               gie,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    output logic [NUM_SRC-1:0] mask,
    output logic               irq_req,
    output logic [ADDR_W-1:0]  irq_vec,
    output logic [ID_W-1:0]    irq_id,
    input  logic               cpu_ack,
    input  logic               cpu_rti,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending
);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] edge_c;
    logic [NUM_SRC-1:0] clr_c;
    logic [NUM_SRC-1:0] onehot_c;
    logic [ID_W-1:0]    sel_id_c;
    logic               sel_any_c;
    logic               sel_valid_c;
    logic               latched_en_c;
    logic [ADDR_W-1:0]  vec_c;
    logic               irq_req_nxt;
    logic               in_service_nxt;
    logic [ID_W-1:0]    irq_id_nxt;
    logic [ADDR_W-1:0]  irq_vec_nxt;

    // Rising-edge detect against the previous sample
    assign edge_c = irq_in & ~irq_q;

    intr_controller_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req     (pending & mask),
        .id_c    (sel_id_c),
        .valid_c (sel_any_c)
    );

    assign sel_valid_c = gie & sel_any_c;

    // Vector address of the selected source; wraps at ADDR_W bits
    assign vec_c = BASE_VEC + (ADDR_W'(sel_id_c) * VEC_STRIDE);

    // Latched source still enabled; otherwise the request is withdrawn
    assign onehot_c     = NUM_SRC'(1) << irq_id;
    assign latched_en_c = gie & (|(mask & onehot_c));

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state;
        irq_req_nxt    = irq_req;
        in_service_nxt = in_service;
        irq_id_nxt     = irq_id;
        irq_vec_nxt    = irq_vec;
        clr_c          = '0;
        case (state)
            ST_IDLE: begin
                if (sel_valid_c) begin
                    state_nxt   = ST_REQ;
                    irq_req_nxt = 1'b1;
                    irq_id_nxt  = sel_id_c;
                    irq_vec_nxt = vec_c;
                end
            end
            ST_REQ: begin
                // Ack takes precedence over withdraw; no preemption while requesting
                if (cpu_ack) begin
                    state_nxt      = ST_SERVICE;
                    irq_req_nxt    = 1'b0;
                    in_service_nxt = 1'b1;
                    clr_c          = onehot_c;
                end else if (!latched_en_c) begin
                    state_nxt   = ST_IDLE;
                    irq_req_nxt = 1'b0;
                end
            end
            ST_SERVICE: begin
                if (cpu_rti) begin
                    state_nxt      = ST_IDLE;
                    in_service_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt      = ST_IDLE;
                irq_req_nxt    = 1'b0;
                in_service_nxt = 1'b0;
            end
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            irq_q      <= '0;
            pending    <= '0;
            mask       <= '0;
            irq_req    <= 1'b0;
            in_service <= 1'b0;
            irq_id     <= '0;
            irq_vec    <= '0;
        end else begin
            state      <= state_nxt;
            irq_q      <= irq_in;
            // A new edge in the ack cycle wins over the clear
            pending    <= (pending & ~clr_c) | edge_c;
            if (mask_we) begin
                mask <= mask_wdata;
            end
            irq_req    <= irq_req_nxt;
            in_service <= in_service_nxt;
            irq_id     <= irq_id_nxt;
            irq_vec    <= irq_vec_nxt;
        end
    end

endmodule

// File: tb/tb_intr_controller.sv
// Self-checking bench for intr_controller: directed scenarios with literal
// expectations followed by randomized traffic checked against a behavioural model.
module tb_intr_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq_in;
    logic        gie;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic [3:0]  mask;
    logic        irq_req;
    logic [31:0] irq_vec;
    logic [1:0]  irq_id;
    logic        cpu_ack;
    logic        cpu_rti;
    logic        in_service;
    logic [3:0]  pending;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: per-source arrays plus "what is outstanding" flags
    bit m_pend [4];
    bit m_mask [4];
    bit m_prev [4];
    bit m_req;
    bit m_serv;
    int m_id;

    intr_controller dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .gie        (gie),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask       (mask),
        .irq_req    (irq_req),
        .irq_vec    (irq_vec),
        .irq_id     (irq_id),
        .cpu_ack    (cpu_ack),
        .cpu_rti    (cpu_rti),
        .in_service (in_service),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge
    task automatic model_step();
        bit np [4];
        int sel;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_pend[i] = 0;
                m_mask[i] = 0;
                m_prev[i] = 0;
            end
            m_req  = 0;
            m_serv = 0;
            m_id   = 0;
        end else begin
            sel = -1;
            for (int i = 3; i >= 0; i--) begin
                if (m_pend[i] && m_mask[i]) sel = i;
            end
            for (int i = 0; i < 4; i++) np[i] = m_pend[i];
            if (m_req) begin
                if (cpu_ack) begin
                    np[m_id] = 0;
                    m_req    = 0;
                    m_serv   = 1;
                end else if (!(gie && m_mask[m_id])) begin
                    m_req = 0;
                end
            end else if (m_serv) begin
                if (cpu_rti) m_serv = 0;
            end else if (gie && sel >= 0) begin
                m_req = 1;
                m_id  = sel;
            end
            for (int i = 0; i < 4; i++) begin
                if (irq_in[i] && !m_prev[i]) np[i] = 1;
                m_prev[i] = irq_in[i];
                m_pend[i] = np[i];
                if (mask_we) m_mask[i] = mask_wdata[i];
            end
        end
    endtask

    // Compare every observable output with the model
    task automatic compare_all();
        logic [3:0]  ep;
        logic [3:0]  em;
        logic [31:0] ev;
        for (int i = 0; i < 4; i++) begin
            ep[i] = m_pend[i];
            em[i] = m_mask[i];
        end
        ev = 32'h100 + 32'(m_id) * 32'h10;
        chk("pending", 32'(pending), 32'(ep));
        chk("mask", 32'(mask), 32'(em));
        chk("irq_req", 32'(irq_req), 32'(m_req));
        chk("in_service", 32'(in_service), 32'(m_serv));
        if (m_req || m_serv) chk("irq_id", 32'(irq_id), 32'(m_id));
        if (m_req) chk("irq_vec", irq_vec, ev);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic write_mask(input logic [3:0] v);
        mask_we    = 1'b1;
        mask_wdata = v;
        tick();
        mask_we    = 1'b0;
    endtask

    task automatic ack_cycle();
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
    endtask

    task automatic rti_cycle();
        cpu_rti = 1'b1;
        tick();
        cpu_rti = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq_in = 4'b1111; gie = 1'b0; mask_we = 1'b0;
        mask_wdata = 4'b0; cpu_ack = 1'b0; cpu_rti = 1'b0;
        #2;

        // Reset held three cycles with all request lines high
        repeat (3) tick();
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_irq_req", 32'(irq_req), 32'h0);
        chk("rst_mask", 32'(mask), 32'h0);
        chk("rst_in_service", 32'(in_service), 32'h0);
        chk("rst_irq_vec", irq_vec, 32'h0);
        chk("rst_irq_id", 32'(irq_id), 32'h0);
        rst = 1'b0; irq_in = 4'b0000;
        tick();

        // Single source 2
        gie = 1'b1;
        write_mask(4'b0100);
        irq_in = 4'b0100; tick();
        chk("s2_pending_set", 32'(pending), 32'h4);
        chk("s2_no_req_yet", 32'(irq_req), 32'h0);
        irq_in = 4'b0000; tick();
        chk("s2_irq_req", 32'(irq_req), 32'h1);
        chk("s2_irq_id", 32'(irq_id), 32'h2);
        chk("s2_irq_vec", irq_vec, 32'h120);
        ack_cycle();
        chk("s2_pending_clr", 32'(pending), 32'h0);
        chk("s2_in_service", 32'(in_service), 32'h1);
        chk("s2_req_drop", 32'(irq_req), 32'h0);
        rti_cycle();
        chk("s2_rti", 32'(in_service), 32'h0);

        // Priority between sources 3 and 1
        write_mask(4'b1111);
        irq_in = 4'b1010; tick();
        irq_in = 4'b0000; tick();
        chk("p_irq_id", 32'(irq_id), 32'h1);
        chk("p_irq_vec", irq_vec, 32'h110);
        ack_cycle();
        rti_cycle();
        chk("p_idle_after_rti", 32'(irq_req), 32'h0);
        tick();
        chk("p_rereq", 32'(irq_req), 32'h1);
        chk("p_irq_id3", 32'(irq_id), 32'h3);
        chk("p_irq_vec3", irq_vec, 32'h130);
        ack_cycle();
        rti_cycle();

        // Mask and gie gating
        write_mask(4'b0000);
        irq_in = 4'b0001; tick();
        irq_in = 4'b0000; tick(); tick();
        chk("m_pending0", 32'(pending), 32'h1);
        chk("m_masked_noreq", 32'(irq_req), 32'h0);
        write_mask(4'b0001);
        tick();
        chk("m_req", 32'(irq_req), 32'h1);
        chk("m_vec", irq_vec, 32'h100);
        gie = 1'b0; tick();
        chk("m_withdraw", 32'(irq_req), 32'h0);
        chk("m_still_pending", 32'(pending), 32'h1);
        gie = 1'b1; tick();
        ack_cycle();
        rti_cycle();

        // New edge colliding with the ack of the same source
        write_mask(4'b0100);
        irq_in = 4'b0100; tick();
        irq_in = 4'b0000; tick();
        chk("c_req", 32'(irq_req), 32'h1);
        irq_in = 4'b0100; cpu_ack = 1'b1; tick();
        irq_in = 4'b0000; cpu_ack = 1'b0;
        chk("c_pending_kept", 32'(pending), 32'h4);
        chk("c_in_service", 32'(in_service), 32'h1);
        rti_cycle();
        tick();
        chk("c_reraise", 32'(irq_req), 32'h1);
        chk("c_reraise_id", 32'(irq_id), 32'h2);
        ack_cycle();

        // Reset while servicing, then a stray rti
        chk("r_in_service", 32'(in_service), 32'h1);
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("r_in_service_clr", 32'(in_service), 32'h0);
        chk("r_pending_clr", 32'(pending), 32'h0);
        rti_cycle();
        chk("r_stray_rti", 32'(in_service), 32'h0);
        chk("r_stray_req", 32'(irq_req), 32'h0);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) irq_in[i] = ~irq_in[i];
            end
            mask_we    = ($urandom_range(0, 7) == 0);
            mask_wdata = 4'($urandom);
            gie        = ($urandom_range(0, 9) != 0);
            cpu_ack    = ($urandom_range(0, 2) == 0);
            cpu_rti    = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
